servo_pwm_gen: RTL and testbench

- Downstream consumer of the 32-bit DUTY PIO output in the nios_security system.
- Turns the Nios-written duty word into a glitch-free PWM waveform for the steering servo.
- Period and control are set through its own Avalon-MM slave; duty and period go into shadow registers that only update at period boundaries.

---
 rtl/servo_pwm_gen_pkg.sv | 21 ++
 rtl/servo_pwm_gen_if.sv | 16 +
 rtl/servo_pwm_gen_pwm_core.sv | 58 +++++
 rtl/servo_pwm_gen.sv | 112 +++++++++++
 tb/tb_servo_pwm_gen.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/servo_pwm_gen_pkg.sv
// rtl/servo_pwm_gen_pkg.sv - register map constants for the servo PWM generator
// Purpose: shared address and CTRL bit definitions, plus the bus write decode.
// Ports: none (package servo_pwm_pkg).
package servo_pwm_pkg;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PERIOD   = 2'd1;
  localparam logic [1:0] ADDR_DUTY_ACT = 2'd2;
  localparam logic [1:0] ADDR_COUNT    = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_INV      = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_IRQ_FLAG = 31;

  // Avalon write strobe is active-low and qualified by chipselect.
  function automatic logic is_write(input logic chipselect, input logic write_n);
    return chipselect & ~write_n;
  endfunction

endpackage

// File: rtl/servo_pwm_gen_if.sv
// rtl/servo_pwm_gen_if.sv - Avalon-MM slave bundle for the servo PWM generator
// Purpose: groups the register bus signals.
// Ports: address[1:0], chipselect, write_n, writedata[31:0], readdata[31:0].
interface servo_pwm_if;
  import servo_pwm_pkg::*;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/servo_pwm_gen_pwm_core.sv
// rtl/servo_pwm_gen_pwm_core.sv - period counter, shadow registers and compare
// Purpose: generates the registered PWM waveform and the period-start tick.
// Ports: clk, reset (sync, active-high), en, inv, duty_in, period in;
//        count, duty_sh, pwm_out, period_tick out.
module pwm_core
  import servo_pwm_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             inv,
  input  logic [CNT_W-1:0] duty_in,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] duty_sh,
  output logic             pwm_out,
  output logic             period_tick
);

  logic [CNT_W-1:0] period_sh;
  logic             wrap;

  // Periods of 0 or 1 degenerate to a counter pinned at 0 that wraps every cycle.
  assign wrap = (period_sh <= CNT_W'(1)) || (count == period_sh - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      duty_sh     <= '0;
      period_sh   <= CNT_W'(DEFAULT_PERIOD);
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
    end else if (!en) begin
      // Shadows track live values so enabling starts with fresh settings.
      count       <= '0;
      duty_sh     <= duty_in;
      period_sh   <= period;
      pwm_out     <= inv;
      period_tick <= 1'b0;
    end else begin
      // Unsigned compare: duty >= period naturally yields a constant-high output.
      pwm_out <= (count < duty_sh) ^ inv;
      if (wrap) begin
        count       <= '0;
        duty_sh     <= duty_in;
        period_sh   <= period;
        period_tick <= 1'b1;
      end else begin
        count       <= count + CNT_W'(1);
        period_tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// rtl/servo_pwm_gen.sv - servo PWM generator top with Avalon-MM register file
// Purpose: CTRL/PERIOD registers, read mux, and the pwm_core instance.
// Ports: clk, reset (sync, active-high), duty_in, bus (servo_pwm_if.slave),
//        pwm_out, period_tick; irq when built with PWM_IRQ_EN.
// Macro PWM_IRQ_EN adds the sticky period interrupt (CTRL bit2 enable, bit31 flag).
module servo_pwm_gen
  import servo_pwm_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] duty_in,
  servo_pwm_if.slave       bus,
  output logic             pwm_out,
  output logic             period_tick
`ifdef PWM_IRQ_EN
  ,
  output logic             irq
`endif
);

  logic             en;
  logic             inv;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] duty_sh;
  logic             wr;
  logic [31:0]      ctrl_word;

  assign wr = is_write(bus.chipselect, bus.write_n);

`ifdef PWM_IRQ_EN
  logic irq_en;
  logic irq_flag;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      en     <= 1'b0;
      inv    <= 1'b0;
      period <= CNT_W'(DEFAULT_PERIOD);
`ifdef PWM_IRQ_EN
      irq_en <= 1'b0;
`endif
    end else if (wr) begin
      case (bus.address)
        ADDR_CTRL: begin
          en     <= bus.writedata[CTRL_EN];
          inv    <= bus.writedata[CTRL_INV];
`ifdef PWM_IRQ_EN
          irq_en <= bus.writedata[CTRL_IRQ_EN];
`endif
        end
        ADDR_PERIOD: period <= bus.writedata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

`ifdef PWM_IRQ_EN
  // Set has priority so a tick coinciding with a clear is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_flag <= 1'b0;
    end else if (period_tick) begin
      irq_flag <= 1'b1;
    end else if (wr && bus.address == ADDR_DUTY_ACT) begin
      irq_flag <= 1'b0;
    end
  end

  assign irq = irq_flag & irq_en;
`endif

  always_comb begin
    ctrl_word           = '0;
    ctrl_word[CTRL_EN]  = en;
    ctrl_word[CTRL_INV] = inv;
`ifdef PWM_IRQ_EN
    ctrl_word[CTRL_IRQ_EN]   = irq_en;
    ctrl_word[CTRL_IRQ_FLAG] = irq_flag;
`endif
  end

  always_comb begin
    case (bus.address)
      ADDR_CTRL:     bus.readdata = ctrl_word;
      ADDR_PERIOD:   bus.readdata = 32'(period);
      ADDR_DUTY_ACT: bus.readdata = 32'(duty_sh);
      default:       bus.readdata = 32'(count);
    endcase
  end

  pwm_core #(
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (DEFAULT_PERIOD)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .inv         (inv),
    .duty_in     (duty_in),
    .period      (period),
    .count       (count),
    .duty_sh     (duty_sh),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb/tb_servo_pwm_gen.sv - self-checking bench for servo_pwm_gen
module tb_servo_pwm_gen;
  import servo_pwm_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] duty_in = '0;
  logic        pwm_out;
  logic        period_tick;
`ifdef PWM_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad   = 0;

  servo_pwm_if bus ();

  servo_pwm_gen dut (
    .clk         (clk),
    .reset       (reset),
    .duty_in     (duty_in),
    .bus         (bus),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
`ifdef PWM_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] period;
    logic [31:0] duty;
    logic        inv;
    logic [9:0]  exp_pat;
    int          exp_ticks;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    #1;
    d              = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic wait_tick(output int cycles);
    bit found;
    found  = 1'b0;
    cycles = 0;
    for (int i = 1; i <= 50 && !found; i++) begin
      @(negedge clk);
      if (period_tick) begin
        found  = 1'b1;
        cycles = i;
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: got no period_tick want one within 50 cycles");
    end
  endtask

  task automatic setup(input logic [31:0] p, input logic [31:0] d, input logic [31:0] ctrl);
    bus_write(ADDR_CTRL, 32'h0);
    duty_in = d;
    bus_write(ADDR_PERIOD, p);
    bus_write(ADDR_CTRL, ctrl);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [9:0]  pat;
    int          tk;
    int          cyc;
    int          h;

    vecs[0]  = '{32'd10, 32'd3,          1'b0, 10'h00E, 1};
    vecs[1]  = '{32'd10, 32'd0,          1'b0, 10'h000, 1};
    vecs[2]  = '{32'd10, 32'd10,         1'b0, 10'h3FF, 1};
    vecs[3]  = '{32'd10, 32'hFFFF_FFFF,  1'b0, 10'h3FF, 1};
    vecs[4]  = '{32'd0,  32'd3,          1'b0, 10'h3FF, 10};
    vecs[5]  = '{32'd1,  32'd0,          1'b0, 10'h000, 10};
    vecs[6]  = '{32'd10, 32'd3,          1'b1, 10'h3F1, 1};
    vecs[7]  = '{32'd10, 32'd0,          1'b1, 10'h3FF, 1};
    vecs[8]  = '{32'd10, 32'd10,         1'b1, 10'h000, 1};
    vecs[9]  = '{32'd10, 32'hFFFF_FFFF,  1'b1, 10'h000, 1};
    vecs[10] = '{32'd0,  32'd3,          1'b1, 10'h000, 10};

    bus.address    = '0;
    bus.writedata  = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pwm", {31'b0, pwm_out}, 32'd0);
    check("rst_tick", {31'b0, period_tick}, 32'd0);
    reset = 1'b0;
    bus_read(ADDR_CTRL, rd);     check("rst_ctrl", rd, 32'd0);
    bus_read(ADDR_PERIOD, rd);   check("rst_period", rd, 32'd1000000);
    bus_read(ADDR_DUTY_ACT, rd); check("rst_duty_act", rd, 32'd0);
    bus_read(ADDR_COUNT, rd);    check("rst_count", rd, 32'd0);
    @(negedge clk);

    // Steady-state waveform per vector, aligned to period_tick
    for (int v = 0; v < 11; v++) begin
      setup(vecs[v].period, vecs[v].duty, {30'b0, vecs[v].inv, 1'b1});
      wait_tick(cyc);
      pat    = '0;
      pat[0] = pwm_out;
      tk     = 1;
      bus_read(ADDR_COUNT, rd);
      check($sformatf("v%0d_count_at_tick", v), rd, 32'd0);
      for (int i = 1; i < 10; i++) begin
        @(negedge clk);
        pat[i] = pwm_out;
        if (period_tick) tk++;
      end
      check($sformatf("v%0d_pattern", v), {22'b0, pat}, {22'b0, vecs[v].exp_pat});
      check($sformatf("v%0d_ticks", v), tk, vecs[v].exp_ticks);
    end

    // Duty change mid-period only applies at the next boundary
    setup(32'd10, 32'd3, 32'h1);
    wait_tick(cyc);
    h = int'(pwm_out);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      h += int'(pwm_out);
    end
    check("mid_highs_0_5", h, 3);
    bus_read(ADDR_COUNT, rd);    check("mid_count5", rd, 32'd5);
    duty_in = 32'd8;
    bus_read(ADDR_DUTY_ACT, rd); check("mid_duty_act_old", rd, 32'd3);
    h = 0;
    for (int i = 6; i <= 9; i++) begin
      @(negedge clk);
      h += int'(pwm_out);
    end
    check("mid_highs_6_9", h, 0);
    @(negedge clk);
    check("mid_tick", {31'b0, period_tick}, 32'd1);
    bus_read(ADDR_DUTY_ACT, rd); check("mid_duty_act_new", rd, 32'd8);
    h = int'(pwm_out);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      h += int'(pwm_out);
    end
    check("mid_highs_next", h, 8);

    // Disable at count=2 with duty 3
    setup(32'd10, 32'd3, 32'h1);
    wait_tick(cyc);
    repeat (2) @(negedge clk);
    bus_read(ADDR_COUNT, rd);    check("dis_count2", rd, 32'd2);
    bus_write(ADDR_CTRL, 32'h0);
    @(negedge clk);
    check("dis_pwm", {31'b0, pwm_out}, 32'd0);
    bus_read(ADDR_COUNT, rd);    check("dis_count", rd, 32'd0);
    h = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      h += int'(pwm_out) + int'(period_tick);
    end
    check("dis_quiet", h, 0);

    // PERIOD write on the wrap edge: old value loads, new one next boundary
    setup(32'd10, 32'd3, 32'h1);
    wait_tick(cyc);
    repeat (9) @(negedge clk);
    bus_read(ADDR_COUNT, rd);    check("pw_count9", rd, 32'd9);
    bus_write(ADDR_PERIOD, 32'd5);
    check("pw_tick_wrap", {31'b0, period_tick}, 32'd1);
    wait_tick(cyc);              check("pw_old_period", cyc, 10);
    wait_tick(cyc);              check("pw_new_period", cyc, 5);

    // Reset mid-pulse
    setup(32'd10, 32'd8, 32'h1);
    wait_tick(cyc);
    repeat (2) @(negedge clk);
    check("rm_pulse_high", {31'b0, pwm_out}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rm_pwm", {31'b0, pwm_out}, 32'd0);
    check("rm_tick", {31'b0, period_tick}, 32'd0);
    bus_read(ADDR_CTRL, rd);     check("rm_ctrl", rd, 32'd0);
    bus_read(ADDR_PERIOD, rd);   check("rm_period", rd, 32'd1000000);
    bus_read(ADDR_DUTY_ACT, rd); check("rm_duty_act", rd, 32'd0);
    bus_read(ADDR_COUNT, rd);    check("rm_count", rd, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

`ifdef PWM_IRQ_EN
    // Sticky interrupt: set after tick, cleared by DUTY_ACT write, set wins
    setup(32'd10, 32'd3, 32'h5);
    wait_tick(cyc);
    check("irq_at_tick", {31'b0, irq}, 32'd0);
    @(negedge clk);
    check("irq_after_tick", {31'b0, irq}, 32'd1);
    bus_read(ADDR_CTRL, rd);     check("irq_ctrl_flag", rd, 32'h8000_0005);
    bus_write(ADDR_DUTY_ACT, 32'hDEAD_BEEF);
    check("irq_cleared", {31'b0, irq}, 32'd0);
    wait_tick(cyc);
    check("irq_before_clash", {31'b0, irq}, 32'd0);
    bus_write(ADDR_DUTY_ACT, 32'h0);
    check("irq_set_wins", {31'b0, irq}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
